// File: rtl/rv_pkg.sv
// Core-wide integer register-file constants shared by decode, forwarding and writeback.
package rv_pkg;
  localparam int unsigned RV_XLEN = 32;
  localparam int unsigned RV_NREG = 32;
  localparam int unsigned RV_AW   = $clog2(RV_NREG);

  typedef logic [RV_AW-1:0] regnum_t;
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending bits for RAW hazard detection: reserve at issue, release at writeback.
module rf_scoreboard
  import rv_pkg::*;
#(
  parameter int unsigned NREG = RV_NREG,
  parameter int unsigned NRD  = 2,
  localparam int unsigned AW  = $clog2(NREG)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [NRD*AW-1:0] RNUM,
  input  logic              WE,
  input  logic [AW-1:0]     WNUM,
  input  logic              RSV_EN,
  input  logic [AW-1:0]     RSV_NUM,
  input  logic              FLUSH,
  output logic [NRD-1:0]    RBUSY,
  output logic              PEND_ANY
);

  logic [NREG-1:0] r_pend;
  logic [NREG-1:0] w_pend_nxt;
  logic [NRD-1:0]  w_busy_nxt;

  // Release is applied before reserve so a same-register reserve wins.
  always_comb begin
    w_pend_nxt = r_pend;
    if (FLUSH) begin
      w_pend_nxt = '0;
    end else begin
      if (WE && (WNUM != '0))        w_pend_nxt[WNUM]    = 1'b0;
      if (RSV_EN && (RSV_NUM != '0)) w_pend_nxt[RSV_NUM] = 1'b1;
    end
    w_pend_nxt[0] = 1'b0;
  end

  always_comb begin
    w_busy_nxt = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      w_busy_nxt[i] = w_pend_nxt[RNUM[i*AW +: AW]];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pend   <= '0;
      RBUSY    <= '0;
      PEND_ANY <= 1'b0;
    end else begin
      r_pend   <= w_pend_nxt;
      RBUSY    <= w_busy_nxt;
      PEND_ANY <= |w_pend_nxt;
    end
  end

endmodule

// File: rtl/rf_multiport.sv
// Multi-read-port integer register file with registered, write-bypassed reads and a pending scoreboard.
module rf_multiport
  import rv_pkg::*;
#(
  parameter int unsigned XLEN = RV_XLEN,
  parameter int unsigned NREG = RV_NREG,
  parameter int unsigned NRD  = 2,
  localparam int unsigned AW  = $clog2(NREG)
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [NRD*AW-1:0]   RNUM,
  output logic [NRD*XLEN-1:0] RDATA,
  output logic [NRD-1:0]      RBUSY,
  input  logic                WE,
  input  logic [AW-1:0]       WNUM,
  input  logic [XLEN-1:0]     WDATA,
  input  logic                RSV_EN,
  input  logic [AW-1:0]       RSV_NUM,
  input  logic                FLUSH,
  output logic                PEND_ANY
);

  logic [XLEN-1:0]     r_regs [NREG];
  logic [AW-1:0]       w_rnum [NRD];
  logic [NRD*XLEN-1:0] w_rdata_nxt;

  always_comb begin
    w_rdata_nxt = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      w_rnum[i] = RNUM[i*AW +: AW];
      if (w_rnum[i] == '0)
        w_rdata_nxt[i*XLEN +: XLEN] = '0;
      else if (WE && (WNUM == w_rnum[i]))
        w_rdata_nxt[i*XLEN +: XLEN] = WDATA;
      else
        w_rdata_nxt[i*XLEN +: XLEN] = r_regs[w_rnum[i]];
    end
  end

  // Entry 0 is held at zero and masked on read, so x0 never needs a special write guard downstream.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int unsigned k = 0; k < NREG; k++) r_regs[k] <= '0;
    end else if (WE && (WNUM != '0)) begin
      r_regs[WNUM] <= WDATA;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) RDATA <= '0;
    else        RDATA <= w_rdata_nxt;
  end

  rf_scoreboard #(
    .NREG (NREG),
    .NRD  (NRD)
  ) u_sb (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .RNUM     (RNUM),
    .WE       (WE),
    .WNUM     (WNUM),
    .RSV_EN   (RSV_EN),
    .RSV_NUM  (RSV_NUM),
    .FLUSH    (FLUSH),
    .RBUSY    (RBUSY),
    .PEND_ANY (PEND_ANY)
  );

endmodule

// File: doc/rf_multiport.md
Name: rf_multiport

Overview:
Parametrised integer register file for the pipelined RV32I core, the successor to the two-read/one-write file. It adds a configurable number of read ports, explicit write enable and asynchronous clear. Reads are registered with write-to-read bypass. A per-register pending (scoreboard) bit is reserved at issue and cleared at writeback, so decode can detect RAW hazards. It sits between decode (read/reserve) and writeback (write/release).

Parameters:
XLEN, 32, data width in bits
NREG, 32, number of architectural registers; register 0 is hardwired zero; must be a power of two and at least 2
NRD, 2, number of read ports, 1..4
AW (localparam), $clog2(NREG), register-number width

Ports:
CLK  in  1  clock; all state updates on posedge
RST_N  in  1  asynchronous active-low reset
RNUM  in  NRD*AW  read register numbers; port i = bits [i*AW +: AW]
RDATA  out  NRD*XLEN  registered read data; port i = bits [i*XLEN +: XLEN]
RBUSY  out  NRD  registered pending flag of the register read on port i
WE  in  1  writeback enable
WNUM  in  AW  writeback register number
WDATA  in  XLEN  writeback data
RSV_EN  in  1  reserve (mark pending) request from issue
RSV_NUM  in  AW  register to reserve
FLUSH  in  1  synchronous clear of all pending bits (pipeline flush)
PEND_ANY  out  1  registered OR of all pending bits

Behaviour:
- Reset (RST_N low, async): all registers 1..NREG-1 = 0, all pending bits = 0, RDATA = 0, RBUSY = 0, PEND_ANY = 0. Reset deassertion mid-traffic: first posedge after release behaves normally.
- Register 0: never written, never pending; reads return 0 and RBUSY = 0 regardless of WE/RSV_EN.
- Write: at posedge with WE=1 and WNUM!=0, REG[WNUM] <= WDATA. WE=0 means no write, whatever WNUM is.
- Read latency is 1 cycle. At posedge, RDATA[i] <= value of REG[RNUM[i]] after this edge's write. If WE=1, WNUM=RNUM[i] and WNUM!=0, RDATA[i] <= WDATA (bypass). Multiple ports may read the same register. The same bypass applies to all ports.
- Pending bits: at posedge, priority FLUSH > reserve > release.
  - FLUSH=1: all pending <= 0. RSV_EN and WE are ignored for pending, but the WE data write still occurs.
  - RSV_EN=1, RSV_NUM!=0: pending[RSV_NUM] <= 1.
  - WE=1, WNUM!=0, and WNUM differs from an active reserve target: pending[WNUM] <= 0.
  - Same register reserved and released in one cycle: stays pending (the new producer wins).
  - Release of a non-pending register: no effect.
- RBUSY[i] <= next-state pending[RNUM[i]], consistent with the bypassed RDATA. A write releasing register r in cycle N makes the cycle-N+1 read show data=WDATA, busy=0.
- PEND_ANY <= OR of next-state pending bits.
- No X propagation: out-of-range indices cannot occur (NREG is a power of two).

Decomposition:
- Shared package rv_pkg: XLEN, NREG, AW constants and the reg-number typedef. These are reused by decode, forwarding and writeback.
- One natural sub-module, rf_scoreboard: pending bit vector, priority logic, RBUSY/PEND_ANY generation. rf_multiport holds the storage array, read muxes and bypass, and instantiates rf_scoreboard.

Test Plan:
- Reset: write regs 1..31 with 0xA5A5_0000+n, assert RST_N low mid-cycle -> RDATA=0 immediately. After release, reading all regs returns 0 and PEND_ANY=0.
- x0: WE=1, WNUM=0, WDATA=0xDEADBEEF; RSV_EN=1, RSV_NUM=0 -> next read of x0 gives RDATA=0, RBUSY=0, PEND_ANY=0.
- Bypass: cycle N: WE=1, WNUM=5, WDATA=0x1234_5678, RNUM port0=5, port1=5 -> cycle N+1 both RDATA=0x1234_5678. Cycle N+2, reading x5 without a write -> still 0x1234_5678.
- Scoreboard: reserve x7 in cycle N -> reading x7 gives RBUSY=1 and PEND_ANY=1. Write x7=0x42 -> next read gives RDATA=0x42, RBUSY=0, PEND_ANY=0.
- Simultaneous: x9 pending; same cycle RSV_EN x9 and WE x9=0x99 -> RDATA=0x99, RBUSY=1. Same cycle reserve x3 and release x4 -> x3 busy, x4 free.
- Flush: reserve x1, x2, x3, then FLUSH=1 with WE x2=0x77 -> all RBUSY=0, PEND_ANY=0, x2 reads 0x77. Repeat with NRD=4, XLEN=64: all four ports read distinct registers correctly.
